// File: rtl/buf_ram_1p_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : buf_ram_1p_arb_pkg                                         |
// | Description : Shared constants for the single-port buffer RAM arbiter:   |
// |               address/data widths and sequencer state encodings.         |
// | Ports       : none (package)                                             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`ifndef PIXEL_WIDTH
`define PIXEL_WIDTH 8
`endif

package buf_ram_1p_arb_pkg;

    // 128-entry buffer, one pixel group (8 pixels) per word
    localparam int c_ADDR_WIDTH = 7;
    localparam int c_DATA_WIDTH = `PIXEL_WIDTH * 8;

    // Sequencer state encoding
    localparam int               c_ST_W    = 2;
    localparam logic [c_ST_W-1:0] c_ST_IDLE = 2'd0;
    localparam logic [c_ST_W-1:0] c_ST_WR   = 2'd1;
    localparam logic [c_ST_W-1:0] c_ST_RD   = 2'd2;

endpackage
`default_nettype wire

// File: rtl/buf_ram_1p_arb_rr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : buf_ram_1p_arb_rr                                          |
// | Description : Two-requester round-robin grant (write / read client).     |
// |               A tie goes to the client that was not granted last.        |
// | Ports       : clk, rst      - clock, synchronous active-high reset       |
// |               i_en          - arbitration allowed this cycle             |
// |               i_req_wr/rd   - level requests                             |
// |               o_gnt_wr/rd   - one-hot grant, combinational               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module buf_ram_1p_arb_rr
    import buf_ram_1p_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_req_wr,
    input  logic i_req_rd,
    output logic o_gnt_wr,
    output logic o_gnt_rd
);

    // 1 = the most recent grant went to the read client
    logic r_last_rd;

    assign o_gnt_wr = i_en & i_req_wr & (~i_req_rd | r_last_rd);
    assign o_gnt_rd = i_en & i_req_rd & (~i_req_wr | ~r_last_rd);

    // Starting as "last = read" lets the write client win the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_rd <= 1'b1;
        end else if (o_gnt_wr) begin
            r_last_rd <= 1'b0;
        end else if (o_gnt_rd) begin
            r_last_rd <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/buf_ram_1p_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : buf_ram_1p_arb                                             |
// | Description : Burst arbiter / sequencer sharing one single-port buffer   |
// |               RAM between a write client and a read client. One burst   |
// |               at a time, one beat per cycle; read data returned with a  |
// |               valid strobe one cycle after each read beat.              |
// | Ports       : clk, rst                 - clock, sync active-high reset   |
// |               wr_req/addr/len/ack      - write burst handshake          |
// |               wr_data_rd/data_i/done   - write beat strobe, data, last  |
// |               rd_req/addr/len/ack      - read burst handshake           |
// |               rd_data_o/vld/done       - read data, valid, last         |
// |               ram_ce/we/addr/data_i    - RAM control and write data     |
// |               ram_data_o               - RAM Q (1-cycle latency)        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module buf_ram_1p_arb
    import buf_ram_1p_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = c_ADDR_WIDTH,
    parameter int DATA_WIDTH = c_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [ADDR_WIDTH-1:0] wr_len,
    output logic                  wr_ack,
    output logic                  wr_data_rd,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic                  wr_done,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [ADDR_WIDTH-1:0] rd_len,
    output logic                  rd_ack,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  rd_data_vld,
    output logic                  rd_done,
    output logic                  ram_ce,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data_i,
    input  logic [DATA_WIDTH-1:0] ram_data_o
);

    logic [c_ST_W-1:0]     r_state;
    logic [c_ST_W-1:0]     w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_cur_addr;
    logic [ADDR_WIDTH-1:0] r_beat_cnt;
    logic                  r_rd_vld;
    logic                  r_rd_last;
    logic                  w_arb_en;
    logic                  w_gnt_wr;
    logic                  w_gnt_rd;
    logic                  w_last_beat;

    // No grant while reset is held, so every output is quiet during reset.
    assign w_arb_en    = (r_state == c_ST_IDLE) && !rst;
    assign w_last_beat = (r_beat_cnt == '0);

    buf_ram_1p_arb_rr u_rr (
        .clk      (clk),
        .rst      (rst),
        .i_en     (w_arb_en),
        .i_req_wr (wr_req),
        .i_req_rd (rd_req),
        .o_gnt_wr (w_gnt_wr),
        .o_gnt_rd (w_gnt_rd)
    );

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_gnt_wr) begin
                    w_state_nxt = c_ST_WR;
                end else if (w_gnt_rd) begin
                    w_state_nxt = c_ST_RD;
                end
            end
            c_ST_WR,
            c_ST_RD: begin
                if (w_last_beat) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        ram_ce     = 1'b0;
        ram_we     = 1'b0;
        ram_data_i = '0;
        wr_data_rd = 1'b0;
        wr_done    = 1'b0;
        case (r_state)
            c_ST_WR: begin
                ram_ce     = 1'b1;
                ram_we     = 1'b1;
                ram_data_i = wr_data_i;
                wr_data_rd = 1'b1;
                wr_done    = w_last_beat;
            end
            c_ST_RD: begin
                ram_ce = 1'b1;
            end
            default: ;
        endcase
    end

    assign wr_ack      = w_gnt_wr;
    assign rd_ack      = w_gnt_rd;
    assign ram_addr    = r_cur_addr;
    assign rd_data_vld = r_rd_vld;
    assign rd_done     = r_rd_vld & r_rd_last;
    // RAM Q passes straight through; masked so idle cycles show zero.
    assign rd_data_o   = r_rd_vld ? ram_data_o : '0;

    // ---------------- address / beat counters ----------------
    // Loaded in the grant cycle; the address wraps naturally at 2**ADDR_WIDTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur_addr <= '0;
            r_beat_cnt <= '0;
        end else if (w_gnt_wr) begin
            r_cur_addr <= wr_addr;
            r_beat_cnt <= wr_len;
        end else if (w_gnt_rd) begin
            r_cur_addr <= rd_addr;
            r_beat_cnt <= rd_len;
        end else if (r_state != c_ST_IDLE) begin
            r_cur_addr <= r_cur_addr + ADDR_WIDTH'(1);
            r_beat_cnt <= r_beat_cnt - ADDR_WIDTH'(1);
        end
    end

    // ---------------- read return pipeline ----------------
    // Tracks the RAM's one-cycle read latency independently of the FSM, so
    // the last data cycle may overlap the next grant cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_vld  <= 1'b0;
            r_rd_last <= 1'b0;
        end else begin
            r_rd_vld  <= (r_state == c_ST_RD);
            r_rd_last <= (r_state == c_ST_RD) && w_last_beat;
        end
    end

endmodule
`default_nettype wire
